// File: rtl/rc5_encrypt_core_if.sv
// Handshake and S-table bus for rc5_encrypt_core.
// The slave side is the encryptor; the master side is the requester plus the S RAM.
interface rc5_encrypt_core_if #(
  parameter int w = 32,
  parameter int r = 12
);
  localparam int t        = 2 * r + 2;
  localparam int t_length = $clog2(t);

  logic                key_ready;
  logic                start;
  logic [w-1:0]        pt_a;
  logic [w-1:0]        pt_b;
  logic [w-1:0]        S_sub_i;
  logic [t_length-1:0] S_address;
  logic [w-1:0]        ct_a;
  logic [w-1:0]        ct_b;
  logic                busy;
  logic                valid;

  modport master (
    output key_ready, start, pt_a, pt_b, S_sub_i,
    input  S_address, ct_a, ct_b, busy, valid
  );

  modport slave (
    input  key_ready, start, pt_a, pt_b, S_sub_i,
    output S_address, ct_a, ct_b, busy, valid
  );
endinterface

// File: rtl/rc5_encrypt_core.sv
// RC5-w/r block encryptor: streams the expanded key table S from a registered-read RAM
// and produces one ciphertext pair per accepted start.
module rc5_encrypt_core #(
  parameter int w = 32,
  parameter int r = 12
) (
  input logic               clk1,
  input logic               rst,
  rc5_encrypt_core_if.slave bus
);
  localparam int lgw      = $clog2(w);
  localparam int t        = 2 * r + 2;
  localparam int t_length = $clog2(t);

  localparam logic [t_length-1:0] IDX_LAST     = t_length'(t - 1);
  localparam logic [t_length-1:0] IDX_PREF_CAP = t_length'(t - 3);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t              state_r, state_s;
  logic [w-1:0]        a_r, a_s;
  logic [w-1:0]        b_r, b_s;
  logic [t_length-1:0] idx_r, idx_s;
  logic [t_length-1:0] addr_s;
  logic [w-1:0]        ct_a_s, ct_b_s;
  logic                busy_s, valid_s;
  logic [w-1:0]        even_val_s, odd_val_s;

  function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [lgw-1:0] amt);
    logic [2*w-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*w-1:w];
  endfunction

  // Next-state, datapath and output computation
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    idx_s      = idx_r;
    addr_s     = bus.S_address;
    ct_a_s     = bus.ct_a;
    ct_b_s     = bus.ct_b;
    busy_s     = bus.busy;
    valid_s    = 1'b0;
    even_val_s = rotl(a_r ^ b_r, b_r[lgw-1:0]) + bus.S_sub_i;
    odd_val_s  = rotl(b_r ^ a_r, a_r[lgw-1:0]) + bus.S_sub_i;

    case (state_r)
      IDLE, DONE: begin
        if (bus.start && bus.key_ready) begin
          a_s     = bus.pt_a;
          b_s     = bus.pt_b;
          addr_s  = {t_length{1'b0}};
          busy_s  = 1'b1;
          state_s = PRIME;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        if (!bus.key_ready) begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          addr_s  = t_length'(1);
          idx_s   = {t_length{1'b0}};
          state_s = RUN;
        end
      end
      RUN: begin
        if (!bus.key_ready) begin
          // Abort wins over completion; ciphertext keeps the previous block.
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          if (idx_r == t_length'(0)) begin
            a_s = a_r + bus.S_sub_i;
          end else if (idx_r == t_length'(1)) begin
            b_s = b_r + bus.S_sub_i;
          end else if (!idx_r[0]) begin
            a_s = even_val_s;
          end else begin
            b_s = odd_val_s;
          end

          // Prefetch two ahead of the word being consumed, saturating at the last entry.
          if (idx_r >= IDX_PREF_CAP) begin
            addr_s = IDX_LAST;
          end else begin
            addr_s = idx_r + t_length'(2);
          end

          if (idx_r == IDX_LAST) begin
            ct_a_s  = a_r;
            ct_b_s  = odd_val_s;
            busy_s  = 1'b0;
            valid_s = 1'b1;
            state_s = DONE;
          end else begin
            idx_s = idx_r + t_length'(1);
          end
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r       <= IDLE;
      a_r           <= {w{1'b0}};
      b_r           <= {w{1'b0}};
      idx_r         <= {t_length{1'b0}};
      bus.S_address <= {t_length{1'b0}};
      bus.ct_a      <= {w{1'b0}};
      bus.ct_b      <= {w{1'b0}};
      bus.busy      <= 1'b0;
      bus.valid     <= 1'b0;
    end else begin
      state_r       <= state_s;
      a_r           <= a_s;
      b_r           <= b_s;
      idx_r         <= idx_s;
      bus.S_address <= addr_s;
      bus.ct_a      <= ct_a_s;
      bus.ct_b      <= ct_b_s;
      bus.busy      <= busy_s;
      bus.valid     <= valid_s;
    end
  end
endmodule

// File: tb/tb_rc5_encrypt_core.sv
// Self-checking bench for rc5_encrypt_core: directed timing/abort/reset cases and
// randomized blocks against a plain RC5-32/12 reference model.
module tb_rc5_encrypt_core;
  localparam int T = 26;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  rc5_encrypt_core_if bus ();

  rc5_encrypt_core dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  logic [31:0] s_mem [T];
  int n_checks = 0;
  int n_fail   = 0;

  // Registered-read S RAM
  always @(posedge clk1) bus.S_sub_i <= s_mem[bus.S_address];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [31:0] mrotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [63:0] model_enc(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] a, b;
    a = pa + s_mem[0];
    b = pb + s_mem[1];
    for (int i = 1; i <= 12; i++) begin
      a = mrotl(a ^ b, int'(b % 32)) + s_mem[2*i];
      b = mrotl(b ^ a, int'(a % 32)) + s_mem[2*i+1];
    end
    return {a, b};
  endfunction

  // RC5 key schedule for a 16-byte all-zero key (c = 4)
  task automatic expand_zero_key();
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = 32'd0;
    s_mem[0] = 32'hB7E15163;
    for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + 32'h9E3779B9;
    a = 32'd0; b = 32'd0; i = 0; j = 0;
    for (int k = 0; k < 3 * T; k++) begin
      s_mem[i] = mrotl(s_mem[i] + a + b, 3);
      a = s_mem[i];
      l[j] = mrotl(l[j] + a + b, int'((a + b) % 32));
      b = l[j];
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endtask

  // Steps until valid; returns steps taken (bound on timeout).
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 60) begin
      step();
      n++;
      if (bus.valid === 1'b1) break;
    end
  endtask

  initial begin
    int n, vcount;
    logic [63:0] exp1, exp2;
    logic [31:0] pa, pb;

    bus.key_ready = 1'b0;
    bus.start     = 1'b0;
    bus.pt_a      = 32'd0;
    bus.pt_b      = 32'd0;
    expand_zero_key();

    // Reset state
    step(); step();
    check("rst_addr",  {59'd0, bus.S_address}, 64'd0);
    check("rst_ct",    {bus.ct_a, bus.ct_b}, 64'd0);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_valid", {63'd0, bus.valid}, 64'd0);
    rst = 1'b0;

    // start without key_ready is ignored
    bus.start = 1'b1;
    step(); step();
    check("nokey_busy", {63'd0, bus.busy}, 64'd0);
    bus.key_ready = 1'b1;

    // Zero-key known answer plus cycle-exact timing
    for (int cyc = 1; cyc <= 28; cyc++) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
      if (cyc <= 26) check("addr_seq", {59'd0, bus.S_address}, 64'(cyc - 1));
      check("busy_win",  {63'd0, bus.busy},  {63'd0, (cyc <= 27)});
      check("valid_win", {63'd0, bus.valid}, {63'd0, (cyc == 28)});
    end
    check("kat_const", {bus.ct_a, bus.ct_b}, {32'hEEDBA521, 32'h6D8F4B15});
    check("kat_model", {bus.ct_a, bus.ct_b}, model_enc(32'd0, 32'd0));
    step();
    check("valid_pulse", {63'd0, bus.valid}, 64'd0);

    // Starts while busy ignored; start in valid cycle accepted back-to-back
    pa = $urandom; pb = $urandom;
    exp1 = model_enc(pa, pb);
    bus.pt_a = pa; bus.pt_b = pb; bus.start = 1'b1;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      step();
      bus.start = (cyc == 5 || cyc == 10);
      bus.pt_a  = $urandom;
      bus.pt_b  = $urandom;
    end
    check("b2b_valid1", {63'd0, bus.valid}, 64'd1);
    check("b2b_ct1", {bus.ct_a, bus.ct_b}, exp1);
    pa = $urandom; pb = $urandom;
    exp2 = model_enc(pa, pb);
    bus.pt_a = pa; bus.pt_b = pb; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(n);
    check("b2b_latency", 64'(n), 64'd27);
    check("b2b_ct2", {bus.ct_a, bus.ct_b}, exp2);

    // Reset at cycle 10 of a run
    bus.pt_a = $urandom; bus.pt_b = $urandom; bus.start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_addr", {59'd0, bus.S_address}, 64'd0);
    check("mid_rst_ct",   {bus.ct_a, bus.ct_b}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_valid", {63'd0, bus.valid}, 64'd0);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.valid === 1'b1) vcount++;
    end
    check("mid_rst_novalid", 64'(vcount), 64'd0);

    // key_ready dropped at cycle 12: abort, previous ciphertext kept
    pa = $urandom; pb = $urandom;
    exp1 = model_enc(pa, pb);
    bus.pt_a = pa; bus.pt_b = pb; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(n);
    check("abort_pre_ct", {bus.ct_a, bus.ct_b}, exp1);
    step();
    bus.pt_a = $urandom; bus.pt_b = $urandom; bus.start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      bus.start = 1'b0;
    end
    bus.key_ready = 1'b0;
    step();
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.valid === 1'b1) vcount++;
    end
    check("abort_novalid", 64'(vcount), 64'd0);
    check("abort_ct_kept", {bus.ct_a, bus.ct_b}, exp1);
    bus.key_ready = 1'b1;

    // Random S tables and random blocks; some blocks force B rotate of 0 or 31
    for (int tbl = 0; tbl < 10; tbl++) begin
      for (int k = 0; k < T; k++) s_mem[k] = $urandom;
      for (int blk = 0; blk < 100; blk++) begin
        pa = $urandom;
        case (blk % 4)
          0: pb = {$urandom, 5'd0}  - s_mem[1];
          1: pb = {$urandom, 5'd31} - s_mem[1];
          default: pb = $urandom;
        endcase
        exp1 = model_enc(pa, pb);
        bus.pt_a = pa; bus.pt_b = pb; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(n);
        check("rand_ct", {bus.ct_a, bus.ct_b}, exp1);
      end
      check("rand_latency", 64'(n), 64'd27);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
